// File: rtl/cci_mpf_prim_counter_table_pkg.sv
// cci_mpf_prim_counter_table_pkg: shared operation encoding for the counter table
package cci_mpf_prim_counter_table_pkg;

   typedef enum logic [1:0] {
      OP_INC        = 2'd0,
      OP_READ       = 2'd1,
      OP_READ_CLEAR = 2'd2
   } t_counter_op;

   // The reserved encoding 3 behaves as a plain READ
   function automatic t_counter_op op_norm(input logic [1:0] op);
      return (op == OP_INC) ? OP_INC : (op == OP_READ_CLEAR) ? OP_READ_CLEAR : OP_READ;
   endfunction

endpackage

// File: rtl/cci_mpf_prim_counter_table_alu.sv
// cci_mpf_prim_counter_table_alu: forwarding select and new-value arithmetic for one request
module cci_mpf_prim_counter_table_alu
   import cci_mpf_prim_counter_table_pkg::*;
#(
   parameter int N_IDX_BITS = 6,
   parameter int N_COUNT_BITS = 32,
   parameter int N_INC_BITS = 8,
   parameter int SATURATE = 0
)
(
   input  t_counter_op op,
   input  logic [N_IDX_BITS-1:0] idx,
   input  logic [N_INC_BITS-1:0] val,
   input  logic [N_COUNT_BITS-1:0] ram_data,
   input  logic h1_valid,
   input  logic [N_IDX_BITS-1:0] h1_idx,
   input  logic [N_COUNT_BITS-1:0] h1_cnt,
   input  logic h2_valid,
   input  logic [N_IDX_BITS-1:0] h2_idx,
   input  logic [N_COUNT_BITS-1:0] h2_cnt,
   output logic [N_COUNT_BITS-1:0] old_val,
   output logic [N_COUNT_BITS-1:0] new_val
);

   logic [N_COUNT_BITS:0] sum;
   logic [N_COUNT_BITS-1:0] inc_val;

   always_comb begin
      old_val = (h1_valid && h1_idx == idx) ? h1_cnt :
                (h2_valid && h2_idx == idx) ? h2_cnt : ram_data;
      sum = {1'b0, old_val} + {{(N_COUNT_BITS+1-N_INC_BITS){1'b0}}, val};
      inc_val = (sum[N_COUNT_BITS] && SATURATE != 0) ? '1 : sum[N_COUNT_BITS-1:0];
      new_val = (op == OP_INC) ? inc_val : (op == OP_READ_CLEAR) ? '0 : old_val;
   end

endmodule

// File: rtl/cci_mpf_prim_ram_dualport_init.sv
// cci_mpf_prim_ram_dualport_init: dual-port RAM that fills itself with INIT_VALUE after reset
module cci_mpf_prim_ram_dualport_init
#(
   parameter int N_ENTRIES = 32,
   parameter int N_DATA_BITS = 64,
   parameter logic [N_DATA_BITS-1:0] INIT_VALUE = '0,
   parameter int N_OUTPUT_REG_STAGES = 0
)
(
   input  logic clk0,
   input  logic reset,
   output logic rdy,
   input  logic wen0,
   input  logic [$clog2(N_ENTRIES)-1:0] addr0,
   input  logic [N_DATA_BITS-1:0] wdata0,
   input  logic wen1,
   input  logic [$clog2(N_ENTRIES)-1:0] addr1,
   input  logic [N_DATA_BITS-1:0] wdata1,
   output logic [N_DATA_BITS-1:0] rdata1
);

   logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
   logic [N_DATA_BITS-1:0] rd_q [N_OUTPUT_REG_STAGES+1];
   logic [$clog2(N_ENTRIES)-1:0] init_idx;
   logic init_done;

   assign rdy = init_done;
   assign rdata1 = rd_q[N_OUTPUT_REG_STAGES];

   always_ff @(posedge clk0) begin
      if (reset) begin
         init_done <= 1'b0;
         init_idx <= '0;
      end
      else if (!init_done) begin
         init_idx <= init_idx + 1'b1;
         init_done <= &init_idx;
      end
   end

   // Port 0 belongs to the fill sequencer until every entry has been written
   always_ff @(posedge clk0) begin
      if (!init_done)
         mem[init_idx] <= INIT_VALUE;
      else if (wen0)
         mem[addr0] <= wdata0;
      if (wen1)
         mem[addr1] <= wdata1;
      rd_q[0] <= mem[addr1];
      for (int i = 1; i <= N_OUTPUT_REG_STAGES; i++)
         rd_q[i] <= rd_q[i-1];
   end

endmodule

// File: rtl/cci_mpf_prim_counter_table.sv
// cci_mpf_prim_counter_table: BRAM counter table with INC/READ/READ_CLEAR at one request per cycle
module cci_mpf_prim_counter_table
   import cci_mpf_prim_counter_table_pkg::*;
#(
   parameter int N_ENTRIES = 64,
   parameter int N_COUNT_BITS = 32,
   parameter int N_INC_BITS = 8,
   parameter int SATURATE = 0
)
(
   input  logic clk0,
   input  logic reset,
   output logic rdy,
   input  logic req_en,
   input  logic [1:0] req_op,
   input  logic [$clog2(N_ENTRIES)-1:0] req_idx,
   input  logic [N_INC_BITS-1:0] req_val,
   output logic rsp_valid,
   output logic [$clog2(N_ENTRIES)-1:0] rsp_idx,
   output logic [N_COUNT_BITS-1:0] rsp_old,
   output logic [N_COUNT_BITS-1:0] rsp_new
);

   localparam int IB = $clog2(N_ENTRIES);

   typedef struct packed {
      logic valid;
      t_counter_op op;
      logic [IB-1:0] idx;
      logic [N_INC_BITS-1:0] val;
   } t_stage;

   typedef struct packed {
      logic valid;
      logic [IB-1:0] idx;
      logic [N_COUNT_BITS-1:0] cnt;
   } t_hist;

   t_stage s1, s2;
   t_hist h1, h2;
   logic [N_COUNT_BITS-1:0] rdata1, s2_data, old_val, new_val;

   // Write-back goes straight into the RAM's input registers; H1/H2 cover the
   // two writes the RAM cannot yet return to a read issued at the same time
   cci_mpf_prim_ram_dualport_init #(
      .N_ENTRIES(N_ENTRIES),
      .N_DATA_BITS(N_COUNT_BITS),
      .INIT_VALUE('0),
      .N_OUTPUT_REG_STAGES(0)
   ) ram (
      .clk0(clk0),
      .reset(reset),
      .rdy(rdy),
      .wen0(s2.valid),
      .addr0(s2.idx),
      .wdata0(new_val),
      .wen1(1'b0),
      .addr1(req_idx),
      .wdata1('0),
      .rdata1(rdata1)
   );

   cci_mpf_prim_counter_table_alu #(
      .N_IDX_BITS(IB),
      .N_COUNT_BITS(N_COUNT_BITS),
      .N_INC_BITS(N_INC_BITS),
      .SATURATE(SATURATE)
   ) alu (
      .op(s2.op),
      .idx(s2.idx),
      .val(s2.val),
      .ram_data(s2_data),
      .h1_valid(h1.valid),
      .h1_idx(h1.idx),
      .h1_cnt(h1.cnt),
      .h2_valid(h2.valid),
      .h2_idx(h2.idx),
      .h2_cnt(h2.cnt),
      .old_val(old_val),
      .new_val(new_val)
   );

   always_ff @(posedge clk0) begin
      s1 <= '{valid: req_en && rdy, op: op_norm(req_op), idx: req_idx, val: req_val};
      s2 <= s1;
      s2_data <= rdata1;
      h1 <= '{valid: s2.valid, idx: s2.idx, cnt: new_val};
      h2 <= h1;
      rsp_valid <= s2.valid;
      rsp_idx <= s2.idx;
      rsp_old <= old_val;
      rsp_new <= new_val;
      if (reset) begin
         s1.valid <= 1'b0;
         s2.valid <= 1'b0;
         h1.valid <= 1'b0;
         h2.valid <= 1'b0;
         rsp_valid <= 1'b0;
      end
   end

   a_req_rdy: assert property (@(posedge clk0) disable iff (reset) !(req_en && !rdy))
      else $error("req_en asserted while table not ready");

endmodule

// File: tb/tb_cci_mpf_prim_counter_table.sv
// tb_cci_mpf_prim_counter_table: directed checks of init, forwarding, arithmetic and reset
module tb_cci_mpf_prim_counter_table;

   localparam logic [1:0] INC = 2'd0, RD = 2'd1, RC = 2'd2, RSV = 2'd3;

   logic clk0 = 1'b0;
   logic reset = 1'b1;
   logic req_en = 1'b0;
   logic [1:0] req_op = '0;
   logic [5:0] req_idx = '0;
   logic [7:0] req_val = '0;
   logic rdy, rsp_valid;
   logic [5:0] rsp_idx;
   logic [31:0] rsp_old, rsp_new;

   logic s_en = 1'b0;
   logic [1:0] s_op = '0;
   logic [1:0] s_idx = '0;
   logic [7:0] s_val = '0;
   logic w_rdy, w_valid, t_rdy, t_valid;
   logic [1:0] w_idx, t_idx;
   logic [7:0] w_old, w_new, t_old, t_new;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk0 = ~clk0;

   cci_mpf_prim_counter_table dut (
      .clk0(clk0), .reset(reset), .rdy(rdy), .req_en(req_en), .req_op(req_op),
      .req_idx(req_idx), .req_val(req_val), .rsp_valid(rsp_valid), .rsp_idx(rsp_idx),
      .rsp_old(rsp_old), .rsp_new(rsp_new)
   );

   cci_mpf_prim_counter_table #(.N_ENTRIES(4), .N_COUNT_BITS(8), .N_INC_BITS(8), .SATURATE(0)) dut_wrap (
      .clk0(clk0), .reset(reset), .rdy(w_rdy), .req_en(s_en), .req_op(s_op),
      .req_idx(s_idx), .req_val(s_val), .rsp_valid(w_valid), .rsp_idx(w_idx),
      .rsp_old(w_old), .rsp_new(w_new)
   );

   cci_mpf_prim_counter_table #(.N_ENTRIES(4), .N_COUNT_BITS(8), .N_INC_BITS(8), .SATURATE(1)) dut_sat (
      .clk0(clk0), .reset(reset), .rdy(t_rdy), .req_en(s_en), .req_op(s_op),
      .req_idx(s_idx), .req_val(s_val), .rsp_valid(t_valid), .rsp_idx(t_idx),
      .rsp_old(t_old), .rsp_new(t_new)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic [5:0] idx, input logic [31:0] old_v, input logic [31:0] new_v);
      chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
      chk({tag, "_idx"}, 64'(rsp_idx), 64'(idx));
      chk({tag, "_old"}, 64'(rsp_old), 64'(old_v));
      chk({tag, "_new"}, 64'(rsp_new), 64'(new_v));
   endtask

   task automatic cycle(input logic en, input logic [1:0] op, input logic [5:0] idx, input logic [7:0] val);
      req_en = en;
      req_op = op;
      req_idx = idx;
      req_val = val;
      @(negedge clk0);
   endtask

   task automatic release_and_wait(input string tag);
      int n;
      logic spur;
      n = 0;
      spur = 1'b0;
      reset = 1'b0;
      while (!rdy && n < 200) begin
         @(posedge clk0);
         #1;
         n++;
         if (rsp_valid) spur = 1'b1;
      end
      chk({tag, "_latency"}, 64'(n), 64'(64));
      chk({tag, "_no_rsp"}, 64'(spur), 64'(0));
      @(negedge clk0);
   endtask

   initial begin
      repeat (3) @(negedge clk0);
      chk("rst_rdy", 64'(rdy), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      release_and_wait("init");
      chk("small_rdy", 64'({w_rdy, t_rdy}), 64'(3));
      // Every entry starts at zero
      for (int i = 0; i < 66; i++) begin
         cycle(i < 64, RD, 6'(i), 8'd0);
         if (i >= 2) begin
            chk("init_rd_valid", 64'(rsp_valid), 64'(1));
            chk("init_rd_idx", 64'(rsp_idx), 64'(i - 2));
            chk("init_rd_old", 64'(rsp_old), 64'(0));
         end
      end
      cycle(0, RD, 6'd0, 8'd0);
      chk("idle", 64'(rsp_valid), 64'(0));
      // Back-to-back increments of one index
      cycle(1, INC, 6'd5, 8'd1);
      cycle(1, INC, 6'd5, 8'd1);
      cycle(1, INC, 6'd5, 8'd1);
      chk_rsp("b2b0", 6'd5, 32'd0, 32'd1);
      cycle(1, INC, 6'd5, 8'd1);
      chk_rsp("b2b1", 6'd5, 32'd1, 32'd2);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("b2b2", 6'd5, 32'd2, 32'd3);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("b2b3", 6'd5, 32'd3, 32'd4);
      cycle(0, RD, 6'd0, 8'd0);
      chk("b2b_end", 64'(rsp_valid), 64'(0));
      // Distance-2 forwarding
      cycle(1, INC, 6'd7, 8'd3);
      cycle(1, RD, 6'd9, 8'd0);
      cycle(1, RD, 6'd7, 8'd0);
      chk_rsp("d2_inc", 6'd7, 32'd0, 32'd3);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("d2_other", 6'd9, 32'd0, 32'd0);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("d2_read", 6'd7, 32'd3, 32'd3);
      // Distance-3: value must come from the RAM
      cycle(1, INC, 6'd11, 8'd3);
      cycle(0, RD, 6'd0, 8'd0);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("d3_inc", 6'd11, 32'd0, 32'd3);
      cycle(1, RD, 6'd11, 8'd0);
      cycle(0, RD, 6'd0, 8'd0);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("d3_read", 6'd11, 32'd3, 32'd3);
      // READ_CLEAR followed immediately by INC
      cycle(1, INC, 6'd2, 8'd9);
      cycle(0, RD, 6'd0, 8'd0);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("rc_set", 6'd2, 32'd0, 32'd9);
      cycle(1, RC, 6'd2, 8'd0);
      cycle(1, INC, 6'd2, 8'd1);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("rc_clear", 6'd2, 32'd9, 32'd0);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("rc_inc", 6'd2, 32'd0, 32'd1);
      // Reserved op leaves the counter alone
      cycle(1, RSV, 6'd2, 8'd77);
      cycle(1, RD, 6'd2, 8'd0);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("rsv", 6'd2, 32'd1, 32'd1);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("rsv_after", 6'd2, 32'd1, 32'd1);
      // 8-bit counters: wrap vs saturate on the same stimulus
      s_en = 1'b1;
      s_op = INC;
      s_idx = 2'd1;
      s_val = 8'd250;
      @(negedge clk0);
      s_val = 8'd10;
      @(negedge clk0);
      s_en = 1'b0;
      @(negedge clk0);
      chk("wrap_set", 64'({w_valid, w_idx, w_old, w_new}), 64'({1'b1, 2'd1, 8'd0, 8'd250}));
      chk("sat_set", 64'({t_valid, t_idx, t_old, t_new}), 64'({1'b1, 2'd1, 8'd0, 8'd250}));
      @(negedge clk0);
      chk("wrap_inc", 64'({w_valid, w_idx, w_old, w_new}), 64'({1'b1, 2'd1, 8'd250, 8'd4}));
      chk("sat_inc", 64'({t_valid, t_idx, t_old, t_new}), 64'({1'b1, 2'd1, 8'd250, 8'd255}));
      // Reset with requests in flight
      cycle(1, INC, 6'd20, 8'd1);
      cycle(1, INC, 6'd20, 8'd1);
      cycle(1, INC, 6'd20, 8'd1);
      req_en = 1'b0;
      reset = 1'b1;
      @(negedge clk0);
      chk("mid_rst_valid0", 64'(rsp_valid), 64'(0));
      chk("mid_rst_rdy0", 64'(rdy), 64'(0));
      @(negedge clk0);
      chk("mid_rst_valid1", 64'(rsp_valid), 64'(0));
      release_and_wait("reinit");
      cycle(1, RD, 6'd20, 8'd0);
      cycle(1, RD, 6'd5, 8'd0);
      cycle(1, RD, 6'd7, 8'd0);
      chk_rsp("reinit20", 6'd20, 32'd0, 32'd0);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("reinit5", 6'd5, 32'd0, 32'd0);
      cycle(0, RD, 6'd0, 8'd0);
      chk_rsp("reinit7", 6'd7, 32'd0, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
